// File: rtl/vote_result_reader.sv
// Vote result reader: snapshots four candidate counts, picks the winner over a
// 4-cycle compare walk, then streams a 7-byte checksummed frame with ready/valid.
module vote_result_reader #(
  parameter logic [7:0] HDR = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mode,
  input  logic       start,
  input  logic [7:0] cand1_vote,
  input  logic [7:0] cand2_vote,
  input  logic [7:0] cand3_vote,
  input  logic [7:0] cand4_vote,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       busy,
  output logic       done,
  output logic [1:0] winner,
  output logic       tie
);

  typedef enum logic [1:0] {IDLE, COMPARE, SEND, DONE} state_e;

  state_e          state_q, state_d;
  logic [3:0][7:0] snap_q, snap_d;
  logic [1:0]      cyc_q, cyc_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      max_q, max_d;
  logic [1:0]      wwin_q, wwin_d;
  logic            wtie_q, wtie_d;
  logic [1:0]      winner_q, winner_d;
  logic            tie_q, tie_d;
  logic            out_valid_q, out_valid_d;
  logic [7:0]      out_data_q, out_data_d;

  logic [7:0]      cur;
  logic [7:0]      cmp_max;
  logic [1:0]      cmp_win;
  logic            cmp_tie;
  logic [7:0][7:0] frame;
  logic [7:0]      res_byte;
  logic [2:0]      idx_nx;

  // One compare step; the working max/winner/tie only reach the outputs at the end.
  always_comb begin
    cur     = snap_q[cyc_q];
    cmp_max = max_q;
    cmp_win = wwin_q;
    cmp_tie = wtie_q;
    if (cyc_q == 2'd0) begin
      cmp_max = cur;
      cmp_win = 2'd0;
      cmp_tie = 1'b0;
    end else if (cur > max_q) begin
      cmp_max = cur;
      cmp_win = cyc_q;
      cmp_tie = 1'b0;
    end else if (cur == max_q) begin
      cmp_tie = 1'b1;
    end
  end

  assign res_byte = {tie_q, 5'b0, winner_q};
  assign frame[0] = HDR;
  assign frame[1] = snap_q[0];
  assign frame[2] = snap_q[1];
  assign frame[3] = snap_q[2];
  assign frame[4] = snap_q[3];
  assign frame[5] = res_byte;
  assign frame[6] = HDR ^ snap_q[0] ^ snap_q[1] ^ snap_q[2] ^ snap_q[3] ^ res_byte;
  assign frame[7] = 8'h00;
  assign idx_nx   = idx_q + 3'd1;

  always_comb begin
    state_d     = state_q;
    snap_d      = snap_q;
    cyc_d       = cyc_q;
    idx_d       = idx_q;
    max_d       = max_q;
    wwin_d      = wwin_q;
    wtie_d      = wtie_q;
    winner_d    = winner_q;
    tie_d       = tie_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    case (state_q)
      IDLE: begin
        out_valid_d = 1'b0;
        if (start && mode) begin
          snap_d  = {cand4_vote, cand3_vote, cand2_vote, cand1_vote};
          cyc_d   = 2'd0;
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        if (!mode) begin
          state_d = IDLE;
        end else begin
          max_d  = cmp_max;
          wwin_d = cmp_win;
          wtie_d = cmp_tie;
          cyc_d  = cyc_q + 2'd1;
          if (cyc_q == 2'd3) begin
            winner_d = cmp_win;
            tie_d    = cmp_tie;
            idx_d    = 3'd0;
            state_d  = SEND;
          end
        end
      end
      SEND: begin
        // First SEND cycle only loads byte 0; after that valid stays up until byte 6 goes.
        if (!mode) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end else if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_data_d  = frame[idx_q];
        end else if (out_ready) begin
          if (idx_q == 3'd6) begin
            out_valid_d = 1'b0;
            state_d     = DONE;
          end else begin
            idx_d      = idx_nx;
            out_data_d = frame[idx_nx];
          end
        end
      end
      DONE: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      snap_q      <= '0;
      cyc_q       <= '0;
      idx_q       <= '0;
      max_q       <= '0;
      wwin_q      <= '0;
      wtie_q      <= 1'b0;
      winner_q    <= '0;
      tie_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      snap_q      <= snap_d;
      cyc_q       <= cyc_d;
      idx_q       <= idx_d;
      max_q       <= max_d;
      wwin_q      <= wwin_d;
      wtie_q      <= wtie_d;
      winner_q    <= winner_d;
      tie_q       <= tie_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign winner    = winner_q;
  assign tie       = tie_q;

endmodule

// File: tb/tb_vote_result_reader.sv
// Bench for vote_result_reader: fixed vectors, stall/abort/reset sequences and
// random frames checked against a max/tie reference model.
module tb_vote_result_reader;

  logic       clk = 1'b0;
  logic       reset, mode, start, out_ready;
  logic [7:0] c1, c2, c3, c4;
  logic       out_valid, busy, done, tie;
  logic [7:0] out_data;
  logic [1:0] winner;

  int         tests = 0;
  int         fails = 0;
  logic [1:0] prev_win;
  logic       prev_tie;

  typedef logic [3:0][7:0] cnt_t;
  typedef struct {
    cnt_t       cnt;
    logic [1:0] win;
    logic       t;
    logic [7:0] b5;
    logic [7:0] ck;
  } vec_t;

  always #5 clk = ~clk;

  vote_result_reader #(.HDR(8'hA5)) dut (
    .clk(clk), .reset(reset), .mode(mode), .start(start),
    .cand1_vote(c1), .cand2_vote(c2), .cand3_vote(c3), .cand4_vote(c4),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .busy(busy), .done(done), .winner(winner), .tie(tie)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic cnt_t mk(input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] c, input logic [7:0] d);
    cnt_t r;
    r[0] = a; r[1] = b; r[2] = c; r[3] = d;
    return r;
  endfunction

  // Winner is the lowest index holding the maximum; tie if the maximum occurs twice or more.
  function automatic void model(input cnt_t cnt, output logic [1:0] w, output logic t,
                                output logic [7:0] b5, output logic [7:0] ck);
    int mx = -1;
    int nmax = 0;
    w = 2'd0;
    for (int i = 0; i < 4; i++)
      if (int'(cnt[i]) > mx) begin mx = int'(cnt[i]); w = 2'(i); end
    for (int i = 0; i < 4; i++)
      if (int'(cnt[i]) == mx) nmax++;
    t  = (nmax > 1);
    b5 = {t, 5'b0, w};
    ck = 8'hA5 ^ b5;
    for (int i = 0; i < 4; i++) ck = ck ^ cnt[i];
  endfunction

  task automatic apply(input cnt_t cnt);
    c1 = cnt[0]; c2 = cnt[1]; c3 = cnt[2]; c4 = cnt[3];
  endtask

  // Accept start, scramble the inputs, and walk to the cycle where byte 0 is shown.
  task automatic start_frame(input cnt_t cnt);
    apply(cnt);
    mode = 1'b1;
    start = 1'b1;
    step;
    start = 1'b0;
    c1 = 8'($urandom); c2 = 8'($urandom); c3 = 8'($urandom); c4 = 8'($urandom);
    chk("busy_after_start", 32'(busy), 1);
    for (int k = 0; k < 4; k++) begin
      chk("winner_hold_compare", 32'(winner), 32'(prev_win));
      chk("tie_hold_compare", 32'(tie), 32'(prev_tie));
      chk("valid_early", 32'(out_valid), 0);
      step;
    end
    chk("valid_early", 32'(out_valid), 0);
    step;
    chk("valid_rise_5th_edge", 32'(out_valid), 1);
  endtask

  task automatic do_frame(input cnt_t cnt, input logic [1:0] w, input logic t,
                          input logic [7:0] b5, input logic [7:0] ck,
                          input bit rnd, input int stall_idx);
    logic [7:0] exp_b[7];
    logic [7:0] held;
    int n = 0;
    int guard = 0;
    int stall = 3;
    exp_b[0] = 8'hA5;
    for (int i = 0; i < 4; i++) exp_b[i+1] = cnt[i];
    exp_b[5] = b5;
    exp_b[6] = ck;
    start_frame(cnt);
    while (n < 7 && guard < 300) begin
      guard++;
      chk("valid_no_gap", 32'(out_valid), 1);
      if (n == stall_idx && stall > 0) begin
        stall--;
        out_ready = 1'b0;
        held = out_data;
        step;
        chk("stall_hold", 32'(out_data), 32'(held));
        chk("stall_value", 32'(out_data), 32'(exp_b[n]));
        chk("stall_valid", 32'(out_valid), 1);
      end else if (rnd && $urandom_range(0, 3) == 0) begin
        out_ready = 1'b0;
        held = out_data;
        step;
        chk("rnd_stall_hold", 32'(out_data), 32'(held));
      end else begin
        out_ready = 1'b1;
        chk($sformatf("byte%0d", n), 32'(out_data), 32'(exp_b[n]));
        n++;
        step;
      end
    end
    out_ready = 1'b1;
    if (n < 7) chk("frame_timeout", 32'(n), 7);
    chk("done_pulse", 32'(done), 1);
    chk("valid_low_in_done", 32'(out_valid), 0);
    chk("winner", 32'(winner), 32'(w));
    chk("tie", 32'(tie), 32'(t));
    step;
    chk("done_one_cycle", 32'(done), 0);
    chk("busy_clear", 32'(busy), 0);
    prev_win = w;
    prev_tie = t;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t       tbl[6];
    cnt_t       rc;
    logic [1:0] mw;
    logic       mt;
    logic [7:0] mb5, mck;

    tbl[0] = '{mk(8'd5,   8'd9,   8'd2,  8'd1),   2'd1, 1'b0, 8'h01, 8'hAB};
    tbl[1] = '{mk(8'd3,   8'd7,   8'd7,  8'd2),   2'd1, 1'b1, 8'h81, 8'h25};
    tbl[2] = '{mk(8'd0,   8'd0,   8'd0,  8'd0),   2'd0, 1'b1, 8'h80, 8'h25};
    tbl[3] = '{mk(8'd255, 8'd255, 8'd0,  8'd255), 2'd0, 1'b1, 8'h80, 8'hDA};
    tbl[4] = '{mk(8'd1,   8'd2,   8'd3,  8'd200), 2'd3, 1'b0, 8'h03, 8'h6E};
    tbl[5] = '{mk(8'd10,  8'd10,  8'd20, 8'd20),  2'd2, 1'b1, 8'h82, 8'h27};

    reset = 1'b0; mode = 1'b0; start = 1'b0; out_ready = 1'b0;
    c1 = 8'd0; c2 = 8'd0; c3 = 8'd0; c4 = 8'd0;
    prev_win = 2'd0; prev_tie = 1'b0;
    #22;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_winner", 32'(winner), 0);
    chk("rst_tie", 32'(tie), 0);
    reset = 1'b1;
    step;

    // start ignored while mode is low
    apply(mk(8'd5, 8'd9, 8'd2, 8'd1));
    start = 1'b1;
    step;
    chk("start_mode0_busy", 32'(busy), 0);
    step;
    chk("start_mode0_busy2", 32'(busy), 0);
    chk("start_mode0_valid", 32'(out_valid), 0);
    start = 1'b0;
    step;

    for (int i = 0; i < 6; i++)
      do_frame(tbl[i].cnt, tbl[i].win, tbl[i].t, tbl[i].b5, tbl[i].ck, 1'b0, -1);

    // back-pressure on byte 2
    do_frame(mk(8'd5, 8'd9, 8'd2, 8'd1), 2'd1, 1'b0, 8'h01, 8'hAB, 1'b0, 2);

    // mode drop while byte 3 is presented
    out_ready = 1'b1;
    start_frame(mk(8'd5, 8'd9, 8'd2, 8'd1));
    repeat (3) step;
    chk("abort_byte3", 32'(out_data), 32'h02);
    mode = 1'b0;
    step;
    chk("abort_valid", 32'(out_valid), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_winner", 32'(winner), 1);
    chk("abort_tie", 32'(tie), 0);
    mode = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step;
      chk("abort_no_done", 32'(done), 0);
    end
    prev_win = 2'd1; prev_tie = 1'b0;
    do_frame(mk(8'd3, 8'd7, 8'd7, 8'd2), 2'd1, 1'b1, 8'h81, 8'h25, 1'b0, -1);

    // mode drop during COMPARE leaves winner/tie untouched
    apply(mk(8'd0, 8'd0, 8'd50, 8'd0));
    start = 1'b1;
    step;
    start = 1'b0;
    step;
    mode = 1'b0;
    step;
    chk("cmp_abort_busy", 32'(busy), 0);
    chk("cmp_abort_winner", 32'(winner), 32'(prev_win));
    chk("cmp_abort_tie", 32'(tie), 32'(prev_tie));
    mode = 1'b1;
    step;
    chk("cmp_abort_idle", 32'(busy), 0);

    // reset in the middle of SEND
    start_frame(mk(8'd5, 8'd9, 8'd2, 8'd1));
    step; step;
    #2 reset = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 0);
    chk("midrst_data", 32'(out_data), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_winner", 32'(winner), 0);
    chk("midrst_tie", 32'(tie), 0);
    #2 reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step;
      chk("post_rst_no_byte", 32'(out_valid), 0);
    end
    prev_win = 2'd0; prev_tie = 1'b0;

    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < 4; i++)
        rc[i] = (r % 3 == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      model(rc, mw, mt, mb5, mck);
      do_frame(rc, mw, mt, mb5, mck, 1'b1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vote_result_reader.md
VOTE_RESULT_READER -- requirements
Module: vote_result_reader

Interface
REQ-001 SHALL have parameter HDR, default 8'hA5, frame header byte.
REQ-002 SHALL have port clk  input  1  single system clock, all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port mode  input  1  1 = result mode; readout permitted only while high.
REQ-005 SHALL have port start  input  1  readout request, sampled on rising clk.
REQ-006 SHALL have ports cand1_vote..cand4_vote  input  8 each  logged candidate vote counts.
REQ-007 SHALL have port out_ready  input  1  downstream accepts out_data this cycle.
REQ-008 SHALL have port out_valid  output  1  out_data holds a valid frame byte.
REQ-009 SHALL have port out_data  output  8  current frame byte.
REQ-010 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-011 SHALL have port done  output  1  one-cycle pulse after the last frame byte is accepted.
REQ-012 SHALL have port winner  output  2  index of winning candidate (0 = cand1 .. 3 = cand4).
REQ-013 SHALL have port tie  output  1  high when two or more candidates share the maximum count.

Function
REQ-014 SHALL implement states IDLE, COMPARE, SEND, DONE.
REQ-015 IDLE -> COMPARE when start=1 and mode=1 at a rising edge; the same edge snapshots all four counts into internal registers.
REQ-016 start SHALL be ignored when mode=0 or when the state is not IDLE.
REQ-017 COMPARE SHALL last exactly 4 cycles; cycle k examines snapshot k (k = 0..3).
REQ-018 Cycle 0 SHALL load max = count0, winner = 0, tie = 0.
REQ-019 Cycles 1..3: count > max -> max, winner updated, tie cleared; count == max -> tie set, winner kept; count < max -> no change.
REQ-020 Comparisons SHALL be unsigned 8-bit; ties SHALL resolve to the lowest index.
REQ-021 winner and tie SHALL update only at the end of COMPARE; they hold their previous values during COMPARE and remain stable until the next COMPARE completes.
REQ-022 SEND SHALL emit a 7-byte frame: HDR, count0, count1, count2, count3, {tie, 5'b0, winner}, checksum.
REQ-023 checksum SHALL be the XOR of frame bytes 0..5.
REQ-024 out_valid SHALL first rise 5 rising edges after the edge that accepts start.
REQ-025 A byte SHALL transfer on a rising edge with out_valid=1 and out_ready=1; the byte index then advances.
REQ-026 While out_valid=1 and out_ready=0, out_data SHALL hold stable.
REQ-027 out_valid SHALL stay high between bytes of the frame; it has no gaps.
REQ-028 Transfer of byte 6 SHALL move the state to DONE; done=1 and out_valid=0 for one cycle; the state then returns to IDLE.
REQ-029 mode=0 sampled in COMPARE or SEND SHALL abort to IDLE at that edge; out_valid=0 and busy=0 the next cycle; no done pulse; winner and tie unchanged.
REQ-030 Input counts changing after the snapshot edge SHALL NOT affect the frame.

Reset
REQ-031 reset=0 SHALL immediately force IDLE, regardless of clk.
REQ-032 Reset values: out_valid=0, out_data=0, busy=0, done=0, winner=0, tie=0, and all snapshot registers 0.
REQ-033 Reset asserted mid-frame SHALL discard the frame; after release, no byte is emitted until a new start is accepted.

Verification
REQ-034 Counts 5, 9, 2, 1, out_ready=1, start pulse -> bytes A5,05,09,02,01,01,AB on 7 consecutive cycles; winner=1; tie=0; done pulses once.
REQ-035 Counts 3, 7, 7, 2 -> winner=1, tie=1, byte 5 = 0x81.
REQ-036 All counts 0 -> winner=0, tie=1, frame A5,00,00,00,00,80,25.
REQ-037 out_ready low for 3 cycles while byte 2 is presented -> out_data stays 0x09 and out_valid stays 1; frame completes intact.
REQ-038 mode dropped during byte 3 -> out_valid=0 next cycle, no done; a later start with mode=1 yields a full new frame.
REQ-039 start with mode=0 -> busy stays 0; reset pulsed mid-SEND -> all outputs 0 immediately.
